// File: rtl/mod_reducer.sv
// Restoring shift-subtract reduction of a 2*WIDTH-bit product modulo a WIDTH-bit modulus,
// one dividend bit per clock, framed by a start/busy/done handshake.
module mod_reducer #(
    parameter int WIDTH = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] x,
    input  logic [WIDTH-1:0]   n,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   r,
    output logic               err
);

    localparam int CW = $clog2(2*WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(2*WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] xs;
    logic [WIDTH-1:0]   ns;
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     t;
    logic [WIDTH:0]     acc_nxt;
    logic [CW-1:0]      cnt;

    // t can reach 2n-1, so compare and subtract at WIDTH+1 bits.
    always_comb begin
        t       = {acc[WIDTH-1:0], xs[2*WIDTH-1]};
        acc_nxt = t;
        if (t >= {1'b0, ns})
            acc_nxt = t - {1'b0, ns};
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = (n == '0) ? S_DONE : S_RUN;
            S_RUN:  if (cnt == LAST) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs   <= '0;
            ns   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            r    <= '0;
            err  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        xs   <= x;
                        ns   <= n;
                        acc  <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    xs  <= xs << 1;
                    cnt <= cnt + 1'b1;
                end
                S_DONE: begin
                    // Results publish on the edge that leaves DONE; r/err then hold until the next one.
                    done <= 1'b1;
                    busy <= 1'b0;
                    err  <= (ns == '0);
                    r    <= (ns == '0) ? '0 : acc[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reducer.sv
// Directed bench for mod_reducer at WIDTH=8: vector table plus handshake and reset sequences.
module tb_mod_reducer;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*W-1:0] x;
    logic [W-1:0]   n;
    logic           busy;
    logic           done;
    logic [W-1:0]   r;
    logic           err;

    int total = 0;
    int bad   = 0;

    mod_reducer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .n(n),
        .busy(busy), .done(done), .r(r), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] xv;
        logic [7:0]  nv;
        logic [7:0]  exp_r;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one cycle; lat counts edges from acceptance to done, bcnt counts busy cycles.
    task automatic run_op(input logic [15:0] xv, input logic [7:0] nv,
                          output int lat, output int bcnt);
        @(negedge clk);
        x = xv; n = nv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x = $urandom_range(0, 65535);
        n = $urandom_range(0, 255);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    initial begin
        int lat, bcnt, seen;
        logic [7:0] r_hold;

        vecs.push_back('{16'h1234, 8'd97,  8'd4,   1'b0});
        vecs.push_back('{16'hFFFF, 8'd255, 8'd0,   1'b0});
        vecs.push_back('{16'hABCD, 8'd1,   8'd0,   1'b0});
        vecs.push_back('{16'h0005, 8'd200, 8'd5,   1'b0});
        vecs.push_back('{16'h1234, 8'd0,   8'd0,   1'b1});
        vecs.push_back('{16'h1234, 8'hFF,  8'd70,  1'b0});
        vecs.push_back('{16'h00FF, 8'h80,  8'd127, 1'b0});
        vecs.push_back('{16'hFFFF, 8'hFE,  8'd3,   1'b0});
        vecs.push_back('{16'h8000, 8'd251, 8'd138, 1'b0});
        vecs.push_back('{16'h0100, 8'd3,   8'd1,   1'b0});
        vecs.push_back('{16'h00C8, 8'd200, 8'd0,   1'b0});
        vecs.push_back('{16'h4000, 8'h81,  8'd1,   1'b0});

        rst = 1'b1; start = 1'b0; x = '0; n = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_r",    r,    0);
        check("reset_err",  err,  0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].xv, vecs[i].nv, lat, bcnt);
            check($sformatf("v%0d_lat", i),  lat,  vecs[i].exp_err ? 1 : 17);
            check($sformatf("v%0d_busy", i), bcnt, vecs[i].exp_err ? 1 : 17);
            check($sformatf("v%0d_r", i),    r,    vecs[i].exp_r);
            check($sformatf("v%0d_err", i),  err,  vecs[i].exp_err);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // r and err hold after done falls
        r_hold = r;
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", done, 0);
        check("hold_r",    r,    r_hold);

        // start re-pulsed mid-RUN is ignored
        @(negedge clk);
        x = 16'h1234; n = 8'd97; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        x = 16'hFFFF; n = 8'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("restart_lat", lat, 17);
        check("restart_r",   r,   4);

        // back-to-back with start held high
        @(negedge clk);
        x = 16'h1234; n = 8'd97; start = 1'b1;
        @(posedge clk); #1;
        x = 16'h4000;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_lat1", lat, 17);
        check("b2b_r1",   r,   4);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 100);
        start = 1'b0;
        check("b2b_interval", lat, 18);
        check("b2b_r2",       r,   88);

        // asynchronous reset mid-RUN
        @(negedge clk);
        x = 16'hFFFF; n = 8'hFE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_r",    r,    0);
        check("arst_err",  err,  0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("arst_no_done", seen, 0);

        run_op(16'h8000, 8'd251, lat, bcnt);
        check("post_rst_lat", lat, 17);
        check("post_rst_r",   r,   138);
        check("post_rst_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
